// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded control and operands for EX, inserts
// bubbles on flush or load-use hazard. Load-use detection is built only with HAZARD_DETECT_EN.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [5:0]        id_opcode_i,
    input  logic [9:0]        id_ctrl_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [DATA_W-1:0] id_rd1_i,
    input  logic [DATA_W-1:0] id_rd2_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [9:0]        ex_ctrl_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [DATA_W-1:0] ex_rd1_o,
    output logic [DATA_W-1:0] ex_rd2_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam int unsigned CTRL_W    = 10;
    // Control bundle order: {MtoR, Urw, Branch, MRead, MWrite, RegDs, AOp[2:0], ALUsrc}
    localparam int unsigned MREAD_BIT = 6;
    localparam logic [5:0]  OP_RTYPE  = 6'b000000;
    localparam logic [5:0]  OP_SW     = 6'b101011;
    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic [DATA_W-1:0] ex_pc4_q,   ex_pc4_d;
    logic [DATA_W-1:0] ex_rd1_q,   ex_rd1_d;
    logic [DATA_W-1:0] ex_rd2_q,   ex_rd2_d;
    logic [DATA_W-1:0] ex_imm_q,   ex_imm_d;
    logic [REG_AW-1:0] ex_rs_q,    ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q,    ex_rt_d;
    logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              hazard_c;

`ifdef HAZARD_DETECT_EN
    logic uses_rt_c;
    logic rs_match_c;
    logic rt_match_c;

    // A load in EX conflicts with a consumer in ID that reads its destination
    always_comb begin
        uses_rt_c  = (id_opcode_i == OP_RTYPE) || (id_opcode_i == OP_SW) ||
                     (id_opcode_i == OP_BEQ);
        rs_match_c = (ex_rt_q == id_rs_i);
        rt_match_c = uses_rt_c && (ex_rt_q == id_rt_i);
        hazard_c   = ex_valid_q && ex_ctrl_q[MREAD_BIT] && (ex_rt_q != '0) &&
                     id_valid_i && (rs_match_c || rt_match_c);
    end
`else
    logic unused_opcode;

    assign unused_opcode = ^{id_opcode_i, OP_RTYPE, OP_SW, OP_BEQ, MREAD_BIT[0]};
    assign hazard_c      = 1'b0;
`endif

    assign stall_o = hazard_c;

    // Next-state: flush beats hold, hold beats hazard, otherwise load sanitised ID slot
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_pc4_d   = ex_pc4_q;
        ex_rd1_d   = ex_rd1_q;
        ex_rd2_d   = ex_rd2_q;
        ex_imm_d   = ex_imm_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rd_d    = ex_rd_q;
        cnt_d      = cnt_q;

        if (flush_i || (!hold_i && hazard_c)) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!hold_i) begin
            ex_valid_d = id_valid_i;
            ex_ctrl_d  = id_valid_i ? id_ctrl_i : CTRL_W'(0);
            ex_pc4_d   = id_pc4_i;
            ex_rd1_d   = id_rd1_i;
            ex_rd2_d   = id_rd2_i;
            ex_imm_d   = id_imm_i;
            ex_rs_d    = id_rs_i;
            ex_rt_d    = id_rt_i;
            ex_rd_d    = id_rd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_pc4_q   <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_pc4_q   <= ex_pc4_d;
            ex_rd1_q   <= ex_rd1_d;
            ex_rd2_q   <= ex_rd2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_ctrl_o    = ex_ctrl_q;
    assign ex_pc4_o     = ex_pc4_q;
    assign ex_rd1_o     = ex_rd1_q;
    assign ex_rd2_o     = ex_rd2_q;
    assign ex_imm_o     = ex_imm_q;
    assign ex_rs_o      = ex_rs_q;
    assign ex_rt_o      = ex_rt_q;
    assign ex_rd_o      = ex_rd_q;
    assign bubble_cnt_o = cnt_q;

endmodule
